// File: rtl/disp_seg_buffer.sv
// Segment shadow buffer: holds one segment byte per digit, tracks changed digits
// in dirty flags, streams them one per transfer over valid/ready, and blanks
// digits that stop being refreshed to mimic LED persistence.
module disp_seg_buffer #(
    parameter int unsigned NDIG        = 8,
    parameter int unsigned HOLD_CYCLES = 4096,
    parameter int unsigned AGE_W       = 13,
    parameter logic [7:0]  BLANK       = 8'h80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr,
    input  logic [7:0] mask,
    input  logic [7:0] data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_digit,
    output logic [7:0] out_data,
    output logic       busy
);

    localparam int unsigned DIG_W = 3;
    localparam int unsigned SUM_W = DIG_W + 1;
    localparam int unsigned SEG_W = 8;

    // Blanking is disabled entirely when HOLD_CYCLES is zero.
    localparam bit               HOLD_EN  = (HOLD_CYCLES != 0);
    localparam logic [AGE_W-1:0] HOLD_AGE = AGE_W'(HOLD_CYCLES);
    localparam logic [AGE_W-1:0] HOLD_M1  = HOLD_EN ? AGE_W'(HOLD_CYCLES - 1) : '0;

    logic [SEG_W-1:0] seg_q [NDIG];
    logic [SEG_W-1:0] seg_d [NDIG];
    logic [AGE_W-1:0] age_q [NDIG];
    logic [AGE_W-1:0] age_d [NDIG];
    logic [NDIG-1:0]  dirty_q;
    logic [NDIG-1:0]  dirty_d;
    logic [DIG_W-1:0] ptr_q;
    logic [DIG_W-1:0] ptr_d;

    logic             out_valid_d;
    logic [DIG_W-1:0] out_digit_d;
    logic [SEG_W-1:0] out_data_d;
    logic             busy_d;

    logic             load;
    logic             found;
    logic [DIG_W-1:0] pick;
    logic [SUM_W-1:0] idx_sum;
    logic             wr_hit;

    // Next-state: issue from the output register, then apply writes and blanking
    // so that a set in the same cycle overrides the issue's clear.
    always_comb begin
        for (int unsigned i = 0; i < NDIG; i++) begin
            seg_d[i] = seg_q[i];
            age_d[i] = age_q[i];
        end
        dirty_d     = dirty_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid;
        out_digit_d = out_digit;
        out_data_d  = out_data;
        found       = 1'b0;
        pick        = '0;
        idx_sum     = '0;
        wr_hit      = 1'b0;

        load = !out_valid || out_ready;

        // Round-robin search for the first dirty digit starting at ptr.
        for (int unsigned j = 0; j < NDIG; j++) begin
            idx_sum = SUM_W'(ptr_q) + SUM_W'(j);
            if (idx_sum >= SUM_W'(NDIG)) begin
                idx_sum = idx_sum - SUM_W'(NDIG);
            end
            if (!found && dirty_q[idx_sum[DIG_W-1:0]]) begin
                found = 1'b1;
                pick  = idx_sum[DIG_W-1:0];
            end
        end

        if (load) begin
            if (found) begin
                out_valid_d   = 1'b1;
                out_digit_d   = pick;
                out_data_d    = seg_q[pick];
                dirty_d[pick] = 1'b0;
                ptr_d         = (pick == DIG_W'(NDIG - 1)) ? '0 : pick + DIG_W'(1);
            end else begin
                out_valid_d = 1'b0;
            end
        end

        // Per-digit write, age and blanking; a write always beats blanking.
        for (int unsigned i = 0; i < NDIG; i++) begin
            wr_hit = wr && mask[i];
            if (HOLD_EN && (age_q[i] < HOLD_AGE)) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end
            if (wr_hit) begin
                seg_d[i] = data;
                age_d[i] = '0;
                if (data != seg_q[i]) begin
                    dirty_d[i] = 1'b1;
                end
            end else if (HOLD_EN && (age_q[i] == HOLD_M1)) begin
                seg_d[i] = BLANK;
                if (seg_q[i] != BLANK) begin
                    dirty_d[i] = 1'b1;
                end
            end
        end

        busy_d = (|dirty_d) | out_valid_d;
    end

    // State and output registers with synchronous reset; reset queues every digit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NDIG; i++) begin
                seg_q[i] <= BLANK;
                age_q[i] <= '0;
            end
            dirty_q   <= '1;
            ptr_q     <= '0;
            out_valid <= 1'b0;
            out_digit <= '0;
            out_data  <= BLANK;
            busy      <= 1'b1;
        end else begin
            for (int unsigned i = 0; i < NDIG; i++) begin
                seg_q[i] <= seg_d[i];
                age_q[i] <= age_d[i];
            end
            dirty_q   <= dirty_d;
            ptr_q     <= ptr_d;
            out_valid <= out_valid_d;
            out_digit <= out_digit_d;
            out_data  <= out_data_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_disp_seg_buffer.sv
// Self-checking bench for disp_seg_buffer: table-driven vectors plus directed
// multi-cycle sequences; a second instance with a short hold exercises blanking.
module tb_disp_seg_buffer;

    logic       clk;
    logic       rst_n;
    logic       wr;
    logic [7:0] mask;
    logic [7:0] data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_digit;
    logic [7:0] out_data;
    logic       busy;

    logic       h_rst_n;
    logic       h_wr;
    logic [7:0] h_mask;
    logic [7:0] h_data;
    logic       h_out_valid;
    logic       h_out_ready;
    logic [2:0] h_out_digit;
    logic [7:0] h_out_data;
    logic       h_busy;

    int n_checks = 0;
    int n_fails  = 0;

    disp_seg_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr        (wr),
        .mask      (mask),
        .data      (data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digit (out_digit),
        .out_data  (out_data),
        .busy      (busy)
    );

    disp_seg_buffer #(.HOLD_CYCLES(16)) dut_h (
        .clk       (clk),
        .rst_n     (h_rst_n),
        .wr        (h_wr),
        .mask      (h_mask),
        .data      (h_data),
        .out_valid (h_out_valid),
        .out_ready (h_out_ready),
        .out_digit (h_out_digit),
        .out_data  (h_out_data),
        .busy      (h_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] mask;
        logic [7:0] data;
        logic       ready;
        logic       ev;
        logic [2:0] edig;
        logic [7:0] edat;
        logic       ebusy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic w, logic [7:0] m, logic [7:0] d, logic r,
                                logic v, logic [2:0] g, logic [7:0] e, logic b);
        vec_t t;
        t.wr = w; t.mask = m; t.data = d; t.ready = r;
        t.ev = v; t.edig = g; t.edat = e; t.ebusy = b;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_xfer(string name, logic [2:0] dig, logic [7:0] dat);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_digit"}, 32'(out_digit), 32'(dig));
        check({name, "_data"},  32'(out_data),  32'(dat));
    endtask

    // Reset the main DUT and confirm the eight blank-digit transfers and idle.
    task automatic reset_and_drain(string name);
        rst_n = 1'b0; wr = 1'b0; out_ready = 1'b1;
        tick();
        check({name, "_rst_valid"}, 32'(out_valid), 32'd0);
        check({name, "_rst_busy"},  32'(busy),      32'd1);
        check({name, "_rst_data"},  32'(out_data),  32'h80);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_xfer($sformatf("%s_drain%0d", name, i), 3'(i), 8'h80);
        end
        tick();
        check({name, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({name, "_idle_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        rst_n = 1'b0; wr = 1'b0; mask = '0; data = '0; out_ready = 1'b1;
        h_rst_n = 1'b0; h_wr = 1'b0; h_mask = '0; h_data = '0; h_out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_digit", 32'(out_digit), 32'd0);
        check("reset_data",  32'(out_data),  32'h80);
        check("reset_busy",  32'(busy),      32'd1);
        rst_n   = 1'b1;
        h_rst_n = 1'b1;

        // Vector table: post-reset drain, single write, rewrite, empty mask
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'(i), 8'h80, 1'b1));
        end
        vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 8'h04, 8'h3F, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1));
        vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'd2, 8'h3F, 1'b1));
        vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 8'h04, 8'h3F, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 8'h00, 8'h55, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));

        foreach (vecs[i]) begin
            wr = vecs[i].wr; mask = vecs[i].mask; data = vecs[i].data;
            out_ready = vecs[i].ready;
            tick();
            check($sformatf("row%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            check($sformatf("row%0d_busy", i),  32'(busy),      32'(vecs[i].ebusy));
            if (vecs[i].ev) begin
                check($sformatf("row%0d_digit", i), 32'(out_digit), 32'(vecs[i].edig));
                check($sformatf("row%0d_data", i),  32'(out_data),  32'(vecs[i].edat));
            end
        end
        wr = 1'b0; mask = '0;

        // Two-digit write under backpressure: digit 0 held, then 0 and 7 in order
        reset_and_drain("t3");
        out_ready = 1'b0; wr = 1'b1; mask = 8'h81; data = 8'h06;
        tick();
        check("t3_wr_valid", 32'(out_valid), 32'd0);
        wr = 1'b0;
        tick();
        check_xfer("t3_first", 3'd0, 8'h06);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_xfer($sformatf("t3_hold%0d", i), 3'd0, 8'h06);
        end
        out_ready = 1'b1;
        tick();
        check_xfer("t3_second", 3'd7, 8'h06);
        tick();
        check("t3_end_valid", 32'(out_valid), 32'd0);
        check("t3_end_busy",  32'(busy),      32'd0);

        // Write to a digit in the same cycle it issues: old value, then new value
        out_ready = 1'b0; wr = 1'b1; mask = 8'h08; data = 8'h3F;
        tick();
        check("t4_wr_valid", 32'(out_valid), 32'd0);
        data = 8'h5B;
        tick();
        check_xfer("t4_old", 3'd3, 8'h3F);
        wr = 1'b0;
        tick();
        check_xfer("t4_hold", 3'd3, 8'h3F);
        check("t4_hold_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        tick();
        check_xfer("t4_new", 3'd3, 8'h5B);
        tick();
        check("t4_end_valid", 32'(out_valid), 32'd0);
        check("t4_end_busy",  32'(busy),      32'd0);

        // Reset while a transfer is stalled drops it
        out_ready = 1'b0; wr = 1'b1; mask = 8'h02; data = 8'h11;
        tick();
        wr = 1'b0;
        tick();
        check_xfer("t6_pending", 3'd1, 8'h11);
        reset_and_drain("t6");

        // Persistence on the short-hold instance: blank exactly once after 17 cycles
        h_wr = 1'b1; h_mask = 8'h20; h_data = 8'h66;
        tick();
        check("t5_wr_valid", 32'(h_out_valid), 32'd0);
        h_wr = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            check($sformatf("t5_c%0d_valid", k), 32'(h_out_valid),
                  32'((k == 1) || (k == 17)));
            if (k == 1) begin
                check("t5_w_digit", 32'(h_out_digit), 32'd5);
                check("t5_w_data",  32'(h_out_data),  32'h66);
            end
            if (k == 17) begin
                check("t5_b_digit", 32'(h_out_digit), 32'd5);
                check("t5_b_data",  32'(h_out_data),  32'h80);
            end
        end

        // Refreshing the same value every 10 cycles keeps the digit lit
        for (int k = 0; k < 60; k++) begin
            h_wr = (k % 10 == 0); h_mask = 8'h20; h_data = 8'h66;
            tick();
            check($sformatf("t5r_c%0d_valid", k), 32'(h_out_valid), 32'(k == 1));
            if (k == 1) begin
                check("t5r_digit", 32'(h_out_digit), 32'd5);
                check("t5r_data",  32'(h_out_data),  32'h66);
            end
        end
        h_wr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
